// File: rtl/bht_write_scheduler.sv
// Write-port scheduler for the 16-set x 4-way branch history table.
// Arbitrates EXE counter updates against ID allocations, owns FIFO replacement pointers.
module bht_write_scheduler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_alloc_req_i,
    input  logic [3:0]  id_set_i,
    input  logic [5:0]  id_tag_i,
    input  logic [9:0]  id_target_i,
    input  logic [1:0]  id_ctr_init_i,
    input  logic        exe_upd_req_i,
    input  logic [3:0]  exe_set_i,
    input  logic [1:0]  exe_way_i,
    input  logic [1:0]  exe_ctr_i,
    output logic        wr_en_o,
    output logic [5:0]  wr_addr_o,
    output logic [18:0] wr_data_o,
    output logic        wr_ctr_only_o,
    output logic        init_busy_o,
    output logic [1:0]  pend_count_o,
    output logic        alloc_drop_o
);

    localparam int unsigned NUM_SETS  = 16;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 19;
    localparam int unsigned LAST_ADDR = 63;

    typedef enum logic {S_INIT, S_RUN} state_e;

    typedef struct packed {
        logic [3:0] set;
        logic [5:0] tag;
        logic [9:0] target;
        logic [1:0] ctr;
    } alloc_t;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [1:0]          ptr_q [NUM_SETS];
    logic [1:0]          ptr_d [NUM_SETS];
    alloc_t              q_q [2];
    alloc_t              q_d [2];
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_ctr_only_q, wr_ctr_only_d;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;

    alloc_t              inc_c;
    alloc_t              alloc_c;
    logic                do_alloc_c;
    logic                direct_c;
    logic                deq_c;
    logic                dup_c;
    logic                enq_c;
    logic [1:0]          cnt_tmp_c;

    assign inc_c = '{set: id_set_i, tag: id_tag_i, target: id_target_i, ctr: id_ctr_init_i};

    // Next-state: sweep in INIT, arbitration and queue management in RUN
    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        ptr_d         = ptr_q;
        q_d           = q_q;
        cnt_d         = cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = '0;
        wr_data_d     = '0;
        wr_ctr_only_d = 1'b0;
        busy_d        = 1'b0;
        drop_d        = 1'b0;
        alloc_c       = '0;
        do_alloc_c    = 1'b0;
        direct_c      = 1'b0;
        deq_c         = 1'b0;
        dup_c         = 1'b0;
        enq_c         = 1'b0;
        cnt_tmp_c     = cnt_q;

        case (state_q)
            S_INIT: begin
                // sweep_q holds the address already on the port
                wr_en_d   = 1'b1;
                busy_d    = 1'b1;
                wr_addr_d = sweep_q + ADDR_W'(1);
                sweep_d   = sweep_q + ADDR_W'(1);
                if (sweep_q == ADDR_W'(LAST_ADDR - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                deq_c = !exe_upd_req_i && (cnt_q != 2'd0);
                if (exe_upd_req_i) begin
                    wr_en_d       = 1'b1;
                    wr_addr_d     = {exe_set_i, exe_way_i};
                    wr_data_d     = {17'b0, exe_ctr_i};
                    wr_ctr_only_d = 1'b1;
                end else if (deq_c) begin
                    alloc_c    = q_q[0];
                    do_alloc_c = 1'b1;
                end else if (id_alloc_req_i) begin
                    alloc_c    = inc_c;
                    do_alloc_c = 1'b1;
                    direct_c   = 1'b1;
                end

                if (do_alloc_c) begin
                    wr_en_d              = 1'b1;
                    wr_addr_d            = {alloc_c.set, ptr_q[alloc_c.set]};
                    wr_data_d            = {1'b1, alloc_c.tag, alloc_c.target, alloc_c.ctr};
                    ptr_d[alloc_c.set]   = ptr_q[alloc_c.set] + 2'd1;
                end

                dup_c = ((cnt_q >= 2'd1) && (q_q[0].set == id_set_i) && (q_q[0].tag == id_tag_i)) ||
                        ((cnt_q == 2'd2) && (q_q[1].set == id_set_i) && (q_q[1].tag == id_tag_i));

                if (id_alloc_req_i && !direct_c && !dup_c) begin
                    if ((cnt_q < 2'd2) || deq_c) begin
                        enq_c = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end

                if (deq_c) begin
                    q_d[0]    = q_q[1];
                    cnt_tmp_c = cnt_q - 2'd1;
                end
                if (enq_c) begin
                    q_d[cnt_tmp_c[0]] = inc_c;
                end
                cnt_d = cnt_tmp_c + {1'b0, enq_c};
            end
            default: state_d = S_INIT;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_INIT;
            sweep_q       <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                ptr_q[i] <= '0;
            end
            q_q[0]        <= '0;
            q_q[1]        <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b1;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_ctr_only_q <= 1'b0;
            busy_q        <= 1'b1;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            ptr_q         <= ptr_d;
            q_q           <= q_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_ctr_only_q <= wr_ctr_only_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign wr_ctr_only_o = wr_ctr_only_q;
    assign init_busy_o   = busy_q;
    assign pend_count_o  = cnt_q;
    assign alloc_drop_o  = drop_q;

endmodule

// File: tb/tb_bht_write_scheduler.sv
// Scoreboard bench for bht_write_scheduler: directed test-plan sequences plus random traffic
// checked against a queue-based reference model.
module tb_bht_write_scheduler;

    logic        clk;
    logic        rst;
    logic        id_alloc_req;
    logic [3:0]  id_set;
    logic [5:0]  id_tag;
    logic [9:0]  id_target;
    logic [1:0]  id_ctr_init;
    logic        exe_upd_req;
    logic [3:0]  exe_set;
    logic [1:0]  exe_way;
    logic [1:0]  exe_ctr;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [18:0] wr_data;
    logic        wr_ctr_only;
    logic        init_busy;
    logic [1:0]  pend_count;
    logic        alloc_drop;

    bht_write_scheduler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_alloc_req_i (id_alloc_req),
        .id_set_i       (id_set),
        .id_tag_i       (id_tag),
        .id_target_i    (id_target),
        .id_ctr_init_i  (id_ctr_init),
        .exe_upd_req_i  (exe_upd_req),
        .exe_set_i      (exe_set),
        .exe_way_i      (exe_way),
        .exe_ctr_i      (exe_ctr),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .wr_ctr_only_o  (wr_ctr_only),
        .init_busy_o    (init_busy),
        .pend_count_o   (pend_count),
        .alloc_drop_o   (alloc_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [18:0] data;
        logic        ctr_only;
    } wr_t;

    typedef struct {
        logic       wr_en;
        logic       busy;
        logic [1:0] pend;
        logic       drop;
    } st_t;

    typedef struct {
        logic [3:0] set;
        logic [5:0] tag;
        logic [9:0] tgt;
        logic [1:0] ctr;
    } ent_t;

    wr_t  exp_wr_q[$];
    st_t  exp_st_q[$];
    ent_t m_pend[$];
    int   m_ptr[16];
    int   m_init;
    bit   started;
    int   tests;
    int   fails;

    function automatic wr_t alloc_wr(input ent_t e);
        wr_t w;
        w.addr     = {e.set, 2'(m_ptr[e.set])};
        w.data     = {1'b1, e.tag, e.tgt, e.ctr};
        w.ctr_only = 1'b0;
        m_ptr[e.set] = (m_ptr[e.set] + 1) % 4;
        return w;
    endfunction

    // Reference model: predicts what the port shows in the cycle after each edge
    always @(posedge clk) begin
        st_t  st;
        wr_t  w;
        ent_t inc;
        bit   direct;
        bit   dup;
        st = '{wr_en: 1'b0, busy: 1'b0, pend: 2'd0, drop: 1'b0};
        inc = '{set: id_set, tag: id_tag, tgt: id_target, ctr: id_ctr_init};
        started = 1'b1;
        if (rst) begin
            m_pend.delete();
            for (int i = 0; i < 16; i++) m_ptr[i] = 0;
            m_init = 1;
            st.wr_en = 1'b1;
            st.busy  = 1'b1;
            exp_wr_q.push_back('{addr: 6'd0, data: 19'd0, ctr_only: 1'b0});
        end else if (m_init < 64) begin
            st.wr_en = 1'b1;
            st.busy  = 1'b1;
            exp_wr_q.push_back('{addr: 6'(m_init), data: 19'd0, ctr_only: 1'b0});
            m_init++;
        end else begin
            direct = 1'b0;
            dup = 1'b0;
            foreach (m_pend[i]) if (m_pend[i].set == id_set && m_pend[i].tag == id_tag) dup = 1'b1;
            if (exe_upd_req) begin
                st.wr_en = 1'b1;
                exp_wr_q.push_back('{addr: {exe_set, exe_way}, data: {17'd0, exe_ctr}, ctr_only: 1'b1});
            end else if (m_pend.size() > 0) begin
                st.wr_en = 1'b1;
                w = alloc_wr(m_pend.pop_front());
                exp_wr_q.push_back(w);
            end else if (id_alloc_req) begin
                st.wr_en = 1'b1;
                direct = 1'b1;
                w = alloc_wr(inc);
                exp_wr_q.push_back(w);
            end
            if (id_alloc_req && !direct && !dup) begin
                if (m_pend.size() < 2) m_pend.push_back(inc);
                else st.drop = 1'b1;
            end
        end
        st.pend = 2'(m_pend.size());
        exp_st_q.push_back(st);
    end

    // Monitor: compares status every cycle and each presented write in order
    always @(negedge clk) begin
        st_t s;
        wr_t w;
        if (started) begin
            tests++;
            if (exp_st_q.size() == 0) begin
                fails++;
                $display("FAIL status_underflow t=%0t", $time);
            end else begin
                s = exp_st_q.pop_front();
                if (wr_en !== s.wr_en || init_busy !== s.busy || pend_count !== s.pend || alloc_drop !== s.drop) begin
                    fails++;
                    $display("FAIL status t=%0t got en=%b busy=%b pend=%0d drop=%b want en=%b busy=%b pend=%0d drop=%b",
                             $time, wr_en, init_busy, pend_count, alloc_drop, s.wr_en, s.busy, s.pend, s.drop);
                end
            end
            if (wr_en === 1'b1) begin
                tests++;
                if (exp_wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected t=%0t got addr=%0d data=%h", $time, wr_addr, wr_data);
                end else begin
                    w = exp_wr_q.pop_front();
                    if (wr_addr !== w.addr || wr_data !== w.data || wr_ctr_only !== w.ctr_only) begin
                        fails++;
                        $display("FAIL write t=%0t got addr=%0d data=%h co=%b want addr=%0d data=%h co=%b",
                                 $time, wr_addr, wr_data, wr_ctr_only, w.addr, w.data, w.ctr_only);
                    end
                end
            end
        end
    end

    task automatic step(input logic req, input logic [3:0] s, input logic [5:0] t, input logic [1:0] c,
                        input logic ex, input logic [3:0] es, input logic [1:0] ew, input logic [1:0] ec);
        id_alloc_req = req;
        id_set       = s;
        id_tag       = t;
        id_target    = {s, t};
        id_ctr_init  = c;
        exe_upd_req  = ex;
        exe_set      = es;
        exe_way      = ew;
        exe_ctr      = ec;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 6'd0, 2'd0, 1'b0, 4'd0, 2'd0, 2'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        started = 1'b0;
        m_init = 0;
        rst = 1'b1;
        id_alloc_req = 1'b0; id_set = '0; id_tag = '0; id_target = '0; id_ctr_init = '0;
        exe_upd_req = 1'b0; exe_set = '0; exe_way = '0; exe_ctr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset sweep with stray allocations that must be ignored
        idle(5);
        step(1'b1, 4'd5, 6'd9, 2'b01, 1'b0, 4'd0, 2'd0, 2'd0);
        step(1'b1, 4'd6, 6'd9, 2'b11, 1'b1, 4'd1, 2'd1, 2'd1);
        idle(65);

        // FIFO replacement in set 5
        for (int i = 1; i <= 5; i++) step(1'b1, 4'd5, 6'(i), 2'b01, 1'b0, 4'd0, 2'd0, 2'd0);
        idle(2);

        // EXE priority with a same-edge allocation
        step(1'b1, 4'd2, 6'd9, 2'b11, 1'b1, 4'd2, 2'd3, 2'b10);
        idle(3);

        // Overflow: 4 EXE cycles, 3 distinct allocations
        step(1'b1, 4'd3, 6'd1, 2'b01, 1'b1, 4'd0, 2'd0, 2'd2);
        step(1'b1, 4'd3, 6'd2, 2'b01, 1'b1, 4'd0, 2'd1, 2'd2);
        step(1'b1, 4'd3, 6'd3, 2'b01, 1'b1, 4'd0, 2'd2, 2'd2);
        step(1'b0, 4'd0, 6'd0, 2'b00, 1'b1, 4'd0, 2'd3, 2'd2);
        idle(4);

        // Duplicate suppression
        step(1'b1, 4'd7, 6'd3, 2'b01, 1'b1, 4'd1, 2'd0, 2'd3);
        step(1'b1, 4'd7, 6'd3, 2'b01, 1'b1, 4'd1, 2'd0, 2'd3);
        idle(4);

        // Reset mid-run with queue full and set 1 pointer at 2
        step(1'b1, 4'd1, 6'd1, 2'b01, 1'b0, 4'd0, 2'd0, 2'd0);
        step(1'b1, 4'd1, 6'd2, 2'b01, 1'b0, 4'd0, 2'd0, 2'd0);
        step(1'b1, 4'd9, 6'd1, 2'b01, 1'b1, 4'd0, 2'd0, 2'd1);
        step(1'b1, 4'd9, 6'd2, 2'b01, 1'b1, 4'd0, 2'd0, 2'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(66);
        step(1'b1, 4'd1, 6'd7, 2'b11, 1'b0, 4'd0, 2'd0, 2'd0);
        idle(3);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            step($urandom_range(0, 99) < 45, 4'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 35, 4'($urandom), 2'($urandom), 2'($urandom));
        end
        idle(5);

        @(negedge clk);
        #1;
        tests++;
        if (exp_wr_q.size() != 0) begin
            fails++;
            $display("FAIL writes_missing got %0d outstanding want 0", exp_wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
